// File: rtl/lcd_cmd_sequencer.sv
// Opcode FIFO and issue sequencer in front of the LCD image-display controller.
// Optional issued-opcode statistics counter: define LCD_SEQ_STATS_EN.
module lcd_cmd_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    host_cmd,
  input  logic          host_valid,
  output logic          host_ready,
  output logic [2:0]    cmd,
  output logic          cmd_valid,
  input  logic          busy,
  input  logic          done,
  output logic [AW:0]   fifo_count,
  output logic          seq_done,
  output logic [7:0]    cmd_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FINISHED} state_t;

  localparam logic [2:0]  OP_WRITE   = 3'd0;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t        state;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  assign fifo_empty = (fifo_count == '0);
  assign host_ready = (fifo_count != FULL_COUNT) && (state != FINISHED);
  assign push       = host_valid && host_ready;

  // The pop decision looks only at registered count/state, so a push never falls through.
  always_comb begin
    // NOTE: default first so every path assigns pop and no latch is inferred.
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = !fifo_empty && !busy;
      ISSUE:   pop = (cmd != OP_WRITE) && !fifo_empty && !busy;
      default: pop = 1'b0;
    endcase
  end

  // NOTE: the storage array is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      seq_done   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      cmd_valid  <= pop;
      if (pop) cmd <= mem[rd_ptr];

      unique case (state)
        IDLE: begin
          if (pop) state <= ISSUE;
        end
        ISSUE: begin
          if (cmd == OP_WRITE) state <= WAIT_DONE;
          else if (!pop)       state <= IDLE;
        end
        WAIT_DONE: begin
          if (done) begin
            seq_done <= 1'b1;
            state    <= FINISHED;
          end
        end
        FINISHED: begin
          state <= FINISHED;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LCD_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)          cmd_count <= '0;
    else if (cmd_valid) cmd_count <= cmd_count + 8'd1;
  end
`else
  assign cmd_count = '0;
`endif

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench: queue-based reference model feeds a scoreboard; a negedge monitor compares.
module tb_lcd_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          reset;
  logic [2:0]    host_cmd;
  logic          host_valid;
  logic          host_ready;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   fifo_count;
  logic          seq_done;
  logic [7:0]    cmd_count;

  lcd_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .done       (done),
    .fifo_count (fifo_count),
    .seq_done   (seq_done),
    .cmd_count  (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else             n_pass++;
  endtask

  // Reference model: RUN issues freely, WR is the cycle a write is on the wire,
  // WAIT awaits done, FIN is terminal.
  typedef enum {M_RUN, M_WR, M_WAIT, M_FIN} mode_t;
  mode_t       mode;
  int unsigned q[$];
  int unsigned exp_q[$];
  bit          exp_valid;
  int unsigned exp_hold;
  int unsigned exp_cnt;
  bit          model_live = 1'b0;
  bit          do_pop;
  bit          do_push;
  int unsigned head;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        exp_q.delete();
        mode       = M_RUN;
        exp_valid  = 1'b0;
        exp_hold   = 0;
        exp_cnt    = 0;
        model_live = 1'b1;
      end else if (model_live) begin
        if (exp_valid) exp_cnt = (exp_cnt + 1) % 256;
        do_push = host_valid && (q.size() != DEPTH) && (mode != M_FIN);
        do_pop  = (mode == M_RUN) && (q.size() > 0) && !busy;
        if (mode == M_WR)               mode = M_WAIT;
        else if (mode == M_WAIT && done) mode = M_FIN;
        exp_valid = do_pop;
        if (do_pop) begin
          head     = q.pop_front();
          exp_hold = head;
          exp_q.push_back(head);
          if (head == 0) mode = M_WR;
        end
        if (do_push) q.push_back(int'(host_cmd));
      end
    end
  end

  // Monitor: consumes the scoreboard on every strobe and checks the visible state each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (model_live && !reset) begin
        check("cmd_valid", cmd_valid, exp_valid);
        if (cmd_valid) begin
          check("sb_has_entry", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("issued_cmd", cmd, exp_q.pop_front());
        end else begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          check("held_cmd", cmd, exp_hold);
        end
        check("fifo_count", fifo_count, q.size());
        check("host_ready", host_ready, (q.size() != DEPTH) && (mode != M_FIN));
        check("seq_done", seq_done, mode == M_FIN);
`ifdef LCD_SEQ_STATS_EN
        check("cmd_count", cmd_count, exp_cnt);
`else
        check("cmd_count", cmd_count, 0);
`endif
      end
    end
  end

  task automatic step(input bit v, input int unsigned op, input bit b, input bit d);
    @(negedge clk);
    host_valid = v;
    host_cmd   = 3'(op);
    busy       = b;
    done       = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    host_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int unsigned op;

  initial begin
    reset      = 1'b1;
    host_valid = 1'b0;
    host_cmd   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_fifo_count", fifo_count, 0);
    check("reset_cmd_valid", cmd_valid, 0);
    check("reset_host_ready", host_ready, 1);

    // Post-reset hold with busy high, then release.
    step(1, 1, 1, 0);
    step(1, 4, 1, 0);
    step(1, 5, 1, 0);
    repeat (67) step(0, 0, 1, 0);
    check("hold_fifo_count", fifo_count, 3);
    check("hold_no_strobe", cmd_valid, 0);
    repeat (6) step(0, 0, 0, 0);

    // Full FIFO while busy.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, (i % 7) + 1, 1, 0);
      if (i >= 8) check("full_host_ready", host_ready, 0);
    end
    step(0, 0, 1, 0);
    check("full_fifo_count", fifo_count, 8);
    repeat (12) step(0, 0, 0, 0);

    // Write handshake: 3, 0, 2 with late done.
    do_reset();
    step(1, 3, 0, 0);
    step(1, 0, 0, 0);
    step(1, 2, 0, 0);
    repeat (64) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("wr_seq_done", seq_done, 1);
    check("wr_fifo_count", fifo_count, 1);
    check("wr_host_ready", host_ready, 0);
    repeat (5) step(1, 6, 0, 1);

    // Busy rising in the cycle of the second strobe.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, i >= 3, 0);
    repeat (5) step(0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 0);

    // Reset while waiting for done.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 5, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    do_reset();
    check("rst_fifo_count", fifo_count, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_host_ready", host_ready, 1);

    // 260 non-write opcodes at full rate.
    do_reset();
    for (int i = 0; i < 260; i++) step(1, (i % 7) + 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);
`ifdef LCD_SEQ_STATS_EN
    check("stats_wrap", cmd_count, 4);
`else
    check("stats_off", cmd_count, 0);
`endif

    // Randomized episodes.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        op = ($urandom % 16 == 0) ? 0 : $urandom_range(1, 7);
        step($urandom % 2 == 0, op, ($urandom % 10) < 3, ($urandom % 20) == 0);
      end
    end

    step(0, 0, 0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
